// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard scoreboard with Tuse/Tnew stall detection
// Optional multiply/divide busy tracking is enabled with HAZARD_SCOREBOARD_MD_EN.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int TNEW_W   = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              d_valid,
  input  logic [4:0]        d_a1,
  input  logic [4:0]        d_a2,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic              d_we,
  input  logic [4:0]        d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_is_md,
  input  logic              d_md_div,
  input  logic              d_md_acc,
  output logic              stall,
  output logic              stall_rs,
  output logic              stall_rt,
  output logic              stall_md,
  output logic              md_busy,
  output logic [15:0]       stall_cnt
);
  localparam int CMP_W = (TNEW_W > 2) ? TNEW_W : 2;

  logic [DEPTH-1:0]             we_q, we_d;
  logic [DEPTH-1:0][4:0]        a3_q, a3_d;
  logic [DEPTH-1:0][TNEW_W-1:0] tnew_q, tnew_d;
  logic [15:0]                  stall_cnt_q, stall_cnt_d;

  logic              rs_hit, rt_hit;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;

  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (we_q[i] && (a3_q[i] != 5'd0) && (a3_q[i] == d_a1)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[i];
      end
      if (we_q[i] && (a3_q[i] != 5'd0) && (a3_q[i] == d_a2)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[i];
      end
    end
  end

  assign stall_rs = d_valid && rs_hit && (d_tuse_rs != 2'd3) && (CMP_W'(d_tuse_rs) < CMP_W'(rs_tnew));
  assign stall_rt = d_valid && rt_hit && (d_tuse_rt != 2'd3) && (CMP_W'(d_tuse_rt) < CMP_W'(rt_tnew));
  assign stall    = stall_rs | stall_rt | stall_md;

  always_comb begin
    we_d   = we_q;
    a3_d   = a3_q;
    tnew_d = tnew_q;
    if (!hold) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        we_d[i]   = we_q[i-1];
        a3_d[i]   = a3_q[i-1];
        tnew_d[i] = (tnew_q[i-1] != '0) ? tnew_q[i-1] - TNEW_W'(1) : '0;
      end
      if (stall || !d_valid) begin
        we_d[0]   = 1'b0;
        a3_d[0]   = 5'd0;
        tnew_d[0] = '0;
      end else begin
        we_d[0]   = d_we;
        a3_d[0]   = d_a3;
        tnew_d[0] = d_tnew;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q        <= '0;
      a3_q        <= '0;
      tnew_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      we_q        <= we_d;
      a3_q        <= a3_d;
      tnew_q      <= tnew_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

`ifdef HAZARD_SCOREBOARD_MD_EN
  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [MD_W-1:0] md_cnt_q, md_cnt_d;

  // The counter keeps running through hold: the unit is not part of the frozen pipeline.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_valid && d_is_md && !stall && !hold) begin
      md_cnt_d = d_md_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign stall_md = d_valid & d_md_acc & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_is_md, d_md_div, d_md_acc, 32'(MULT_CYC), 32'(DIV_CYC)};
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL be parameterised as follows:
- DEPTH, default 3: number of in-flight destination slots tracked after D (E, M, W).
- TNEW_W, default 2: width of the Tnew fields.
- MULT_CYC, default 5: mult/multu/madd busy cycles.
- DIV_CYC, default 10: div/divu busy cycles.

REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.

REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- hold, in, 1: global pipeline freeze.
- d_valid, in, 1: D-stage instruction valid.
- d_a1, in, 5: rs read address.
- d_a2, in, 5: rt read address.
- d_tuse_rs, in, 2: cycles until rs is needed; 3 = rs not read.
- d_tuse_rt, in, 2: cycles until rt is needed; 3 = rt not read.
- d_we, in, 1: D instruction writes the GPR file.
- d_a3, in, 5: destination register.
- d_tnew, in, TNEW_W: cycles, counted from E entry, until the result is forwardable.
- d_is_md, in, 1: D instruction starts mult/div.
- d_md_div, in, 1: 1 = div class, 0 = mult class.
- d_md_acc, in, 1: D instruction uses HI/LO (mult, div, mfhi, mflo, mthi, mtlo, madd).
- stall, out, 1: freeze PC and D, inject a bubble into E.
- stall_rs, out, 1: stall cause is rs.
- stall_rt, out, 1: stall cause is rt.
- stall_md, out, 1: stall cause is the multiply/divide unit.
- md_busy, out, 1: multiply/divide unit occupied.
- stall_cnt, out, 16: saturating count of stall cycles.

Function
REQ-004 The block SHALL hold DEPTH slots of {we, a3[4:0], tnew[TNEW_W-1:0]}; slot 0 is E.
REQ-005 When hold=0, slot[i+1] SHALL load slot[i] with tnew decremented and saturated at 0.
REQ-006 When hold=0, slot 0 SHALL load a bubble (we=0, a3=0, tnew=0) if stall=1 or d_valid=0.
REQ-007 When hold=0 and the slot-0 bubble condition does not apply, slot 0 SHALL load {d_we, d_a3, d_tnew}.
REQ-008 The contents of the oldest slot SHALL be discarded on each shift.
REQ-009 When hold=1, all slots SHALL remain unchanged and no tnew SHALL decrement.
REQ-010 A slot SHALL match rs when we=1, a3!=0 and a3==d_a1; rt matching SHALL use d_a2 identically.
REQ-011 Only the youngest (lowest-index) matching slot SHALL be considered for each operand; older matches SHALL be ignored.
REQ-012 stall_rs SHALL equal d_valid AND a youngest rs match exists AND d_tuse_rs < match.tnew; stall_rt SHALL be defined identically for rt.
REQ-013 A Tuse value of 3 SHALL never cause a stall.
REQ-014 stall SHALL equal stall_rs | stall_rt | stall_md, combinationally from current slot state and D inputs, with zero-cycle latency.
REQ-015 stall_cnt SHALL increment by 1 on each clock edge with stall=1 and hold=0, and SHALL saturate at 16'hFFFF.
REQ-016 stall_rs and stall_rt MAY both be 1 in the same cycle, and stall_cnt SHALL then count that cycle once.

Configuration
REQ-017 With macro HAZARD_SCOREBOARD_MD_EN defined, the block SHALL contain a multiply/divide busy counter md_cnt, width clog2(max(MULT_CYC, DIV_CYC)+1).
REQ-018 With HAZARD_SCOREBOARD_MD_EN defined, md_cnt SHALL load DIV_CYC (d_md_div=1) or MULT_CYC (d_md_div=0) on an edge with d_valid & d_is_md & ~stall & ~hold.
REQ-019 With HAZARD_SCOREBOARD_MD_EN defined, md_cnt SHALL otherwise decrement by 1 each cycle while nonzero, independent of hold.
REQ-020 With HAZARD_SCOREBOARD_MD_EN defined, md_busy SHALL equal (md_cnt != 0), and stall_md SHALL equal d_valid & d_md_acc & md_busy.
REQ-021 With HAZARD_SCOREBOARD_MD_EN defined, a new mult/div SHALL NOT be issued while md_busy=1, because d_md_acc covers start instructions.
REQ-022 Without HAZARD_SCOREBOARD_MD_EN, the counter SHALL be absent, md_busy and stall_md SHALL be tied 0, and d_is_md, d_md_div and d_md_acc SHALL be ignored.

Reset
REQ-023 While reset_n=0, all slots SHALL be cleared to bubbles, and md_cnt and stall_cnt SHALL be 0, independent of clk.
REQ-024 Consequently, during and immediately after reset, stall, stall_rs, stall_rt, stall_md and md_busy SHALL be 0 for any D inputs.
REQ-025 Reset asserted mid-operation (slots populated, md_cnt nonzero) SHALL discard all state within the same cycle.

Verification
REQ-026 Load-use: issue lw with d_a3=8 and d_tnew=2, then add with d_a1=8 and d_tuse_rs=0 -> stall=1 and stall_rs=1 for exactly 2 cycles, then 0, and stall_cnt=2.
REQ-027 Youngest match: slot0 holds {we=1, a3=5, tnew=0} and slot1 holds {we=1, a3=5, tnew=1}, with d_a2=5 and d_tuse_rt=0 -> stall=0.
REQ-028 $zero and Tuse=3: d_a3=0 with d_tnew=2 followed by d_a1=0; and d_tuse_rs=3 against any match -> stall=0 in both cases.
REQ-029 Hold: a pending stall with hold=1 held for 4 cycles -> slots and stall_cnt frozen and stall held at 1; stall releases 2 cycles after hold drops.
REQ-030 Multiply/divide (HAZARD_SCOREBOARD_MD_EN defined): issue div with DIV_CYC=10, then mflo -> md_busy=1 for 10 cycles and stall_md=1 during those 10 cycles; undefined macro -> stall_md=0 for the same stimulus.
REQ-031 Reset mid-op: assert reset_n=0 with md_cnt=7 and a stall pending -> all outputs 0 asynchronously, and stall_cnt=0 after release.
